lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
Parametrised load/store bus controller between the CPU execute stage and N memory-mapped slaves (ROM, RAM, UART, future peripherals).
- Decodes the region from addr[31:24].
- Runs a req/ack handshake with variable slave wait states.
- Generates byte enables and lane-replicated write data.
- Sign/zero-extends load data.
- Flags misaligned, unmapped and timed-out accesses with a cause code.

Parameters:
NUM_REGIONS, 3, number of slaves; region r decoded when addr[31:24]==r, for r < NUM_REGIONS
ADDR_W, 24, slave address width; slv_addr = addr[ADDR_W-1:0]
TIMEOUT, 15, maximum wait cycles in ACCESS before a bus-error response (1..2^TO_W-1)
TO_W, 4, timeout counter width

Ports:
CLK  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  1  access request from CPU; sampled only in IDLE
addr  in  32  byte address
wdata  in  32  store data, right-aligned
size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
wr  in  1  1 = store, 0 = load
busy  out  1  high in every non-IDLE state
ack  out  1  one-cycle completion pulse
rdata  out  32  extended load data; valid with ack, held until next ack
exception  out  1  high with ack when the access faulted
exc_cause  out  2  0 none, 1 misaligned/illegal size, 2 unmapped, 3 timeout; valid with ack
slv_sel  out  NUM_REGIONS  one-hot slave strobe
slv_wr  out  1  write strobe qualifier
slv_addr  out  ADDR_W  latched address; low two bits forced to 0
slv_be  out  4  byte enables, for loads and stores
slv_wdata  out  32  lane-replicated store data
slv_rdata  in  32*NUM_REGIONS  slave read data; slave r on bits [32r+31:32r]
slv_ready  in  NUM_REGIONS  per-slave ready; may be combinational in the same cycle as slv_sel

Behaviour:
Reset (async, any state):
- State goes to IDLE.
- busy, ack, exception, slv_sel, slv_wr, slv_be, slv_wdata and rdata all go to 0; exc_cause goes to 0.
- Timeout counter clears.
- An access in flight is abandoned with no ack.

States: IDLE, ACCESS, RESP.

IDLE:
- On req=1, latch addr, wdata, size and wr.
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, or size in {011, 110, 111} -> cause 1, go to RESP.
- Else if addr[31:24] >= NUM_REGIONS -> cause 2, go to RESP.
- Else go to ACCESS; counter = 0.
- Faulting accesses never assert slv_sel.

ACCESS:
- slv_sel[region]=1, with slv_wr, slv_be, slv_addr and slv_wdata driven from latched values, all held stable.
- If slv_ready[region]=1: capture data and go to RESP; for loads capture the extended slv_rdata, for stores rdata=0.
- Else if counter==TIMEOUT: cause 3 and go to RESP, with slv_sel dropped next cycle.
- Else counter increments.

RESP (one cycle):
- ack=1, exception=(cause!=0), busy=1.
- Next state is IDLE. req is not accepted in this cycle.

Latency: req at cycle 0 -> slv_sel at cycle 1 -> ready at cycle 1 -> ack at cycle 2. Each wait cycle adds 1. A fault acks at cycle 1.

Lanes (o = addr[1:0]):
- B/BU: be = 0001<<o; wdata replicated as {4{wdata[7:0]}}.
- H/HU: be = 0011<<o; wdata replicated as {2{wdata[15:0]}}.
- W: be = 1111; wdata passed through.

Loads:
- lane = slv_rdata >> (8*o).
- B sign-extends lane[7]; BU zero-extends.
- H sign-extends lane[15]; HU zero-extends.
- W passes through.

General rules:
- req while busy is ignored; the CPU holds req until ack.
- A slv_ready bit of a non-selected region is ignored.
- Only the most recent access updates rdata and exc_cause; on a fault rdata = 0.

Test Plan:
- LW to 0x0100_0004 with slave 1 ready after 2 waits and slv_rdata=0xDEADBEEF -> sel=010 for cycles 1-3, be=1111, ack at cycle 4, rdata=0xDEADBEEF, exception=0.
- LB at 0x0100_0003 with rdata=0x80xxxxxx -> be=1000, rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
- SH at 0x0000_0002 with wdata=0x1234ABCD, slave 0 ready immediately -> slv_wdata=0xABCDABCD, be=1100, slv_wr=1, ack at cycle 2.
- LW to 0x0100_0002 -> ack at cycle 1, exception=1, cause=1, slv_sel never asserted; LW to 0x0500_0000 -> cause=2.
- Access to region 2 with slv_ready held low, TIMEOUT=15 -> sel high for 16 cycles, then ack, cause=3; slave 0's ready pulsing during this is ignored.
- reset_n low during ACCESS -> slv_sel, busy and ack go to 0 immediately; after release a new req completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: decodes a region from addr[31:24], runs a req/ack
// handshake with the selected slave, and aligns/extends data with fault reporting.
module lsu_bus_ctrl #(
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT     = 15,
  parameter int TO_W        = 4
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic                          req,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  input  logic [2:0]                    size,
  input  logic                          wr,
  output logic                          busy,
  output logic                          ack,
  output logic [31:0]                   rdata,
  output logic                          exception,
  output logic [1:0]                    exc_cause,
  output logic [NUM_REGIONS-1:0]        slv_sel,
  output logic                          slv_wr,
  output logic [ADDR_W-1:0]             slv_addr,
  output logic [3:0]                    slv_be,
  output logic [31:0]                   slv_wdata,
  input  logic [32*NUM_REGIONS-1:0]     slv_rdata,
  input  logic [NUM_REGIONS-1:0]        slv_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                   r_state, w_next;
  logic [31:0]              r_addr, r_wdata, r_rdata;
  logic [2:0]               r_size;
  logic                     r_wr;
  logic [TO_W-1:0]          r_cnt;
  logic [1:0]               r_cause;

  logic                     w_misal, w_unmap, w_rdy, w_timeout;
  logic [NUM_REGIONS-1:0]   w_sel;
  logic [31:0]              w_rword, w_lane, w_ext, w_wdrep;
  logic [3:0]               w_be;
  logic [1:0]               w_off;

  // Fault checks use the live request so a bad access never reaches a slave.
  always_comb begin
    w_misal = 1'b0;
    case (size)
      3'b000, 3'b100: w_misal = 1'b0;
      3'b001, 3'b101: w_misal = addr[0];
      3'b010:         w_misal = |addr[1:0];
      default:        w_misal = 1'b1;
    endcase
    w_unmap = (addr[31:24] >= 8'(NUM_REGIONS));
  end

  always_comb begin
    w_sel   = '0;
    w_rdy   = 1'b0;
    w_rword = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_addr[31:24] == 8'(i)) begin
        w_sel[i] = 1'b1;
        w_rdy    = slv_ready[i];
        w_rword  = slv_rdata[32*i +: 32];
      end
    end
  end

  assign w_off  = r_addr[1:0];
  assign w_lane = w_rword >> {w_off, 3'b000};

  always_comb begin
    w_be    = 4'b1111;
    w_wdrep = r_wdata;
    w_ext   = w_lane;
    case (r_size[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdrep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
    case (r_size)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ext = {24'h0, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ext = {16'h0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Slave strobes exist only in ACCESS, so reset or a fault can never leave them up.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    ack       = 1'b0;
    slv_sel   = '0;
    slv_wr    = 1'b0;
    slv_be    = '0;
    slv_wdata = '0;
    w_timeout = (r_cnt == TO_W'(TIMEOUT));
    case (r_state)
      S_IDLE: begin
        if (req) w_next = (w_misal || w_unmap) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        busy      = 1'b1;
        slv_sel   = w_sel;
        slv_wr    = r_wr;
        slv_be    = w_be;
        slv_wdata = w_wdrep;
        if (w_rdy || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        busy   = 1'b1;
        ack    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
      r_cause <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_size  <= size;
            r_wr    <= wr;
            r_cnt   <= '0;
            if (w_misal) begin
              r_cause <= 2'd1;
              r_rdata <= '0;
            end else if (w_unmap) begin
              r_cause <= 2'd2;
              r_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (w_rdy) begin
            r_cause <= 2'd0;
            r_rdata <= r_wr ? 32'h0 : w_ext;
          end else if (w_timeout) begin
            r_cause <= 2'd3;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exception = ack && (r_cause != 2'd0);
  assign exc_cause = r_cause;
  assign rdata     = r_rdata;
  assign slv_addr  = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed table-driven bench for lsu_bus_ctrl with a cycle-accurate slave
// responder, plus hand sequences for reset behaviour.
module tb_lsu_bus_ctrl;

  localparam int NR = 3;

  logic            CLK = 1'b0;
  logic            reset_n;
  logic            req;
  logic [31:0]     addr, wdata;
  logic [2:0]      size;
  logic            wr;
  logic            busy, ack, exception;
  logic [31:0]     rdata;
  logic [1:0]      exc_cause;
  logic [NR-1:0]   slv_sel;
  logic            slv_wr;
  logic [23:0]     slv_addr;
  logic [3:0]      slv_be;
  logic [31:0]     slv_wdata;
  logic [32*NR-1:0] slv_rdata;
  logic [NR-1:0]   slv_ready;

  lsu_bus_ctrl #(.NUM_REGIONS(NR), .ADDR_W(24), .TIMEOUT(15), .TO_W(4)) dut (
    .CLK(CLK), .reset_n(reset_n), .req(req), .addr(addr), .wdata(wdata),
    .size(size), .wr(wr), .busy(busy), .ack(ack), .rdata(rdata),
    .exception(exception), .exc_cause(exc_cause), .slv_sel(slv_sel),
    .slv_wr(slv_wr), .slv_addr(slv_addr), .slv_be(slv_be),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] rword;
    int          waits;
    logic        noise;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    logic        expExc;
    logic [1:0]  expCause;
    int          expLat;
    logic [2:0]  expSel;
  } vec_t;

  vec_t vecs[13];

  int checks = 0;
  int errors = 0;

  int          obsLat, selCnt;
  logic [2:0]  obsSel;
  logic [3:0]  obsBe;
  logic [31:0] obsWdata, obsRdata;
  logic [23:0] obsAddr;
  logic        obsWr, obsExc, obsStable, busyBad;
  logic [1:0]  obsCause;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    addr      = v.addr;
    wdata     = v.wdata;
    size      = v.size;
    wr        = v.wr;
    req       = 1'b1;
    slv_ready = '0;
    for (int r = 0; r < NR; r++) begin
      slv_rdata[32*r +: 32] = v.expSel[r] ? v.rword : (32'h0BAD_0000 | 32'(r));
    end
    obsLat = -1; selCnt = 0; obsSel = '0; obsStable = 1'b1; busyBad = 1'b0;
    obsBe = '0; obsWdata = '0; obsWr = 1'b0; obsAddr = '0;
    for (int cyc = 1; cyc <= 40 && obsLat < 0; cyc++) begin
      @(negedge CLK);
      if (!busy) busyBad = 1'b1;
      if (ack) begin
        obsLat   = cyc;
        obsRdata = rdata;
        obsExc   = exception;
        obsCause = exc_cause;
        req      = 1'b0;
        slv_ready = '0;
      end else begin
        if (slv_sel != '0) begin
          if (selCnt == 0) begin
            obsBe = slv_be; obsWdata = slv_wdata; obsWr = slv_wr; obsAddr = slv_addr;
          end else if (slv_be !== obsBe || slv_wdata !== obsWdata ||
                       slv_wr !== obsWr || slv_addr !== obsAddr || slv_sel !== obsSel) begin
            obsStable = 1'b0;
          end
          obsSel |= slv_sel;
          selCnt++;
        end
        slv_ready = v.noise ? ({NR{cyc[0]}} & ~v.expSel) : '0;
        if (v.waits >= 0 && selCnt > v.waits) slv_ready |= v.expSel;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0100_0004, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF, 2,  1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'd0, 4,  3'b010};
    vecs[1]  = '{32'h0100_0003, 32'h0, 3'b000, 1'b0, 32'h8012_3456, 0,  1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 2'd0, 2,  3'b010};
    vecs[2]  = '{32'h0100_0003, 32'h0, 3'b100, 1'b0, 32'h8012_3456, 0,  1'b0, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2'd0, 2,  3'b010};
    vecs[3]  = '{32'h0000_0002, 32'h1234_ABCD, 3'b001, 1'b1, 32'h1111_2222, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 2'd0, 2, 3'b001};
    vecs[4]  = '{32'h0100_0002, 32'h0, 3'b010, 1'b0, 32'h0, 0,  1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1, 1,  3'b000};
    vecs[5]  = '{32'h0500_0000, 32'h0, 3'b010, 1'b0, 32'h0, 0,  1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd2, 1,  3'b000};
    vecs[6]  = '{32'h0200_0000, 32'h0, 3'b010, 1'b0, 32'h7777_7777, -1, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 2'd3, 17, 3'b100};
    vecs[7]  = '{32'h0000_0002, 32'h0, 3'b001, 1'b0, 32'h8001_1234, 0,  1'b0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2'd0, 2,  3'b001};
    vecs[8]  = '{32'h0000_0000, 32'h0, 3'b101, 1'b0, 32'h1234_F00D, 0,  1'b0, 4'b0011, 32'h0, 32'h0000_F00D, 1'b0, 2'd0, 2,  3'b001};
    vecs[9]  = '{32'h0200_0001, 32'h0000_00A5, 3'b000, 1'b1, 32'h0, 1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 2'd0, 3, 3'b100};
    vecs[10] = '{32'h0000_0004, 32'hCAFE_F00D, 3'b010, 1'b1, 32'h0, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 2'd0, 2, 3'b001};
    vecs[11] = '{32'h0000_0000, 32'h0, 3'b011, 1'b0, 32'h0, 0,  1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1, 1,  3'b000};
    vecs[12] = '{32'h0000_0001, 32'h0, 3'b001, 1'b0, 32'h0, 0,  1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1, 1,  3'b000};

    reset_n = 1'b0; req = 1'b0; addr = '0; wdata = '0; size = '0; wr = 1'b0;
    slv_rdata = '0; slv_ready = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_sel", 32'(slv_sel), 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_cause", 32'(exc_cause), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_latency", i), 32'(obsLat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d_sel", i), 32'(obsSel), 32'(vecs[i].expSel));
      checkOutput($sformatf("v%0d_sel_cycles", i), 32'(selCnt),
                  (vecs[i].expSel != 0) ? 32'(vecs[i].expLat - 1) : 32'h0);
      checkOutput($sformatf("v%0d_rdata", i), obsRdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_exception", i), 32'(obsExc), 32'(vecs[i].expExc));
      checkOutput($sformatf("v%0d_cause", i), 32'(obsCause), 32'(vecs[i].expCause));
      checkOutput($sformatf("v%0d_busy", i), 32'(busyBad), 32'h0);
      if (vecs[i].expSel != 0) begin
        checkOutput($sformatf("v%0d_be", i), 32'(obsBe), 32'(vecs[i].expBe));
        checkOutput($sformatf("v%0d_wr", i), 32'(obsWr), 32'(vecs[i].wr));
        checkOutput($sformatf("v%0d_stable", i), 32'(obsStable), 32'h1);
        checkOutput($sformatf("v%0d_slv_addr", i), 32'(obsAddr), {8'h0, vecs[i].addr[23:2], 2'b00});
        if (vecs[i].wr) checkOutput($sformatf("v%0d_wdata", i), obsWdata, vecs[i].expWdata);
      end
    end

    // Reset asserted mid-ACCESS must drop the strobes at once and abandon the access.
    @(negedge CLK);
    addr = 32'h0100_0000; size = 3'b010; wr = 1'b0; req = 1'b1; slv_ready = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_pre_sel", 32'(slv_sel), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_sel", 32'(slv_sel), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    req = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("rst_idle_busy", 32'(busy), 32'h0);
    checkOutput("rst_no_ack", 32'(ack), 32'h0);
    applyStimulus(vecs[0]);
    checkOutput("post_rst_latency", 32'(obsLat), 32'h4);
    checkOutput("post_rst_rdata", obsRdata, 32'hDEAD_BEEF);
    checkOutput("post_rst_cause", 32'(obsCause), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
